// File: rtl/touch_ctrl.sv
// touch_ctrl: two-flop synchronizer and debouncer for a raw capacitive touch
// input, followed by a timing FSM that classifies gestures as single tap,
// double tap or long press. Gesture events are registered one-cycle pulses;
// the debounced level is exported as `touched`.
module touch_ctrl #(
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned LONG_CYC     = 100000000,
  parameter int unsigned DTAP_CYC     = 30000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch_signal,
  input  logic       enable,
  output logic       touched,
  output logic       tap,
  output logic       double_tap,
  output logic       long_press,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  // Terminal counts are compared against the value before the increment, so
  // each threshold is the cycle count minus one.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DTAP_LAST = CNT_W'(DTAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync_q, sync_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             touched_q, touched_d;
  logic             touched_prev_q, touched_prev_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_cnt_q, t_cnt_d;
  logic [CNT_W-1:0] t_cnt_inc;
  logic             tap_q, tap_d;
  logic             double_tap_q, double_tap_d;
  logic             long_press_q, long_press_d;
  logic             rise;
  logic             fall;
  logic             long_hit;
  logic             dtap_hit;

  // Synchronizer chain, debounce tracking and previous-level capture.
  always_comb begin
    sync1_d        = touch_signal;
    sync_d         = sync1_q;
    touched_prev_d = touched_q;
    touched_d      = touched_q;
    db_cnt_d       = '0;
    if (sync_q != touched_q) begin
      if (db_cnt_q == DB_LAST) begin
        touched_d = ~touched_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end
  end

  // Register the synchronizer, debounce counter and debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync_q         <= 1'b0;
      db_cnt_q       <= '0;
      touched_q      <= 1'b0;
      touched_prev_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync_q         <= sync_d;
      db_cnt_q       <= db_cnt_d;
      touched_q      <= touched_d;
      touched_prev_q <= touched_prev_d;
    end
  end

  // Edge detection and terminal-count decodes shared by the FSM processes.
  always_comb begin
    rise      = touched_q & ~touched_prev_q;
    fall      = ~touched_q & touched_prev_q;
    long_hit  = (t_cnt_q == LONG_LAST);
    dtap_hit  = (t_cnt_q == DTAP_LAST);
    t_cnt_inc = (t_cnt_q == CNT_MAX) ? t_cnt_q : (t_cnt_q + CNT_ONE);
  end

  // FSM state register together with the shared gesture timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      t_cnt_q <= t_cnt_d;
    end
  end

  // Next-state logic; a falling edge beats a long-press timeout and a rising
  // edge beats the double-tap window expiring.
  always_comb begin
    state_d = state_q;
    t_cnt_d = t_cnt_inc;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) state_d = PRESS1;
        end
        PRESS1: begin
          if (fall) state_d = GAP;
          else if (touched_q && long_hit) state_d = HELD;
        end
        GAP: begin
          if (rise) state_d = PRESS2;
          else if (dtap_hit) state_d = IDLE;
        end
        PRESS2: begin
          if (fall) state_d = IDLE;
          else if (long_hit) state_d = HELD;
        end
        HELD: begin
          if (fall) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (!enable || (state_d != state_q) || (state_q == IDLE) || (state_q == HELD)) begin
      t_cnt_d = '0;
    end
  end

  // Output decode: the pulse matching the transition being taken this cycle.
  always_comb begin
    tap_d        = 1'b0;
    double_tap_d = 1'b0;
    long_press_d = 1'b0;
    if (enable) begin
      case (state_q)
        PRESS1: begin
          if (!fall && touched_q && long_hit) long_press_d = 1'b1;
        end
        GAP: begin
          if (!rise && dtap_hit) tap_d = 1'b1;
        end
        PRESS2: begin
          if (fall) double_tap_d = 1'b1;
          else if (long_hit) long_press_d = 1'b1;
        end
        default: begin
          tap_d        = 1'b0;
          double_tap_d = 1'b0;
          long_press_d = 1'b0;
        end
      endcase
    end
  end

  // Pulse registers so every event is a clean single-cycle output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q        <= 1'b0;
      double_tap_q <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      tap_q        <= tap_d;
      double_tap_q <= double_tap_d;
      long_press_q <= long_press_d;
    end
  end

  assign touched    = touched_q;
  assign tap        = tap_q;
  assign double_tap = double_tap_q;
  assign long_press = long_press_q;
  assign state      = state_q;

endmodule

// File: tb/tb_touch_ctrl.sv
// tb_touch_ctrl: directed gesture scenarios plus randomized touch/enable/reset
// traffic, checked every cycle against a timestamp-based gesture model.
module tb_touch_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 50;
  localparam int DTAP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       touch_signal = 1'b0;
  logic       enable = 1'b1;
  logic       touched;
  logic       tap;
  logic       double_tap;
  logic       long_press;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model: raw input delay line, stable-run debounce, and a gesture
  // tracked as "presses seen / currently pressed / time the phase began".
  bit m_raw [2];
  bit m_touched, m_prev;
  int m_run;
  bit m_active, m_pressed, m_held;
  int m_presses, m_cyc, m_tstart;
  bit m_tap, m_dtap, m_long;

  // Observed-event bookkeeping used by the directed literal checks.
  int ncyc = 0;
  int tap_cnt = 0, dtap_cnt = 0, long_cnt = 0, rise_cnt = 0;
  int rise_at = 0, fall_at = 0, tap_at = 0, dtap_at = 0, long_at = 0;
  bit mon_prev = 1'b0;

  touch_ctrl #(
    .CNT_W       (8),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG),
    .DTAP_CYC    (DTAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .touch_signal(touch_signal),
    .enable      (enable),
    .touched     (touched),
    .tap         (tap),
    .double_tap  (double_tap),
    .long_press  (long_press),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic int expState();
    if (!m_active) return 0;
    if (m_held) return 4;
    if (!m_pressed) return 2;
    return (m_presses == 2) ? 3 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit t, input bit en, input bit r, input int cycles);
    touch_signal = t;
    enable = en;
    rst = r;
    repeat (cycles) @(negedge clk);
  endtask

  // Advance the model by one clock edge using the pre-edge model values.
  always @(posedge clk) begin
    bit rise_e, fall_e;
    if (rst) begin
      m_raw[0] = 0; m_raw[1] = 0;
      m_touched = 0; m_prev = 0; m_run = 0;
      m_active = 0; m_pressed = 0; m_held = 0;
      m_presses = 0; m_cyc = 0; m_tstart = 0;
      m_tap = 0; m_dtap = 0; m_long = 0;
    end else begin
      rise_e = m_touched && !m_prev;
      fall_e = !m_touched && m_prev;
      m_tap = 0; m_dtap = 0; m_long = 0;
      m_cyc++;
      if (!enable) begin
        m_active = 0; m_held = 0; m_pressed = 0;
      end else if (!m_active) begin
        if (rise_e) begin
          m_active = 1; m_presses = 1; m_pressed = 1; m_held = 0; m_tstart = m_cyc;
        end
      end else if (m_held) begin
        if (fall_e) begin m_active = 0; m_held = 0; m_pressed = 0; end
      end else if (m_pressed) begin
        if (fall_e) begin
          if (m_presses == 2) begin m_dtap = 1; m_active = 0; m_pressed = 0; end
          else begin m_pressed = 0; m_tstart = m_cyc; end
        end else if (m_cyc - m_tstart == LONG) begin
          m_long = 1; m_held = 1;
        end
      end else begin
        if (rise_e) begin
          m_presses = 2; m_pressed = 1; m_tstart = m_cyc;
        end else if (m_cyc - m_tstart == DTAP) begin
          m_tap = 1; m_active = 0;
        end
      end
      m_prev = m_touched;
      if (m_raw[1] != m_touched) begin
        m_run++;
        if (m_run == DEB) begin m_touched = !m_touched; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_raw[1] = m_raw[0];
      m_raw[0] = touch_signal;
    end
  end

  // Per-cycle comparison against the model plus event bookkeeping.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("touched", touched, m_touched);
      checkOutput("tap", tap, m_tap);
      checkOutput("double_tap", double_tap, m_dtap);
      checkOutput("long_press", long_press, m_long);
      checkOutput("state", state, expState());
      if (tap === 1'b1) begin tap_cnt++; tap_at = ncyc; end
      if (double_tap === 1'b1) begin dtap_cnt++; dtap_at = ncyc; end
      if (long_press === 1'b1) begin long_cnt++; long_at = ncyc; end
      if (touched === 1'b1 && !mon_prev) begin rise_cnt++; rise_at = ncyc; end
      if (touched === 1'b0 && mon_prev) fall_at = ncyc;
      mon_prev = (touched === 1'b1);
    end
  end

  initial begin
    int t0, s_tap, s_dtap, s_long;
    int r;
    // Reset and glitch rejection.
    applyStimulus(0, 1, 1, 3);
    check_en = 1'b1;
    #1;
    checkOutput("reset_touched", touched, 0);
    checkOutput("reset_tap", tap, 0);
    checkOutput("reset_dtap", double_tap, 0);
    checkOutput("reset_long", long_press, 0);
    checkOutput("reset_state", state, 0);
    applyStimulus(1, 1, 0, 3);
    applyStimulus(0, 1, 0, 20);
    #1;
    checkOutput("glitch_no_rise", rise_cnt, 0);
    checkOutput("glitch_no_pulse", tap_cnt + dtap_cnt + long_cnt, 0);

    // Single tap: one edge to detect the fall, then the DTAP window.
    t0 = ncyc; s_tap = tap_cnt; s_dtap = dtap_cnt; s_long = long_cnt;
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("tap_rise_latency", rise_at - t0, 2 + DEB);
    checkOutput("tap_count", tap_cnt - s_tap, 1);
    checkOutput("tap_delay", tap_at - fall_at, 1 + DTAP);
    checkOutput("tap_no_dtap", dtap_cnt - s_dtap, 0);
    checkOutput("tap_no_long", long_cnt - s_long, 0);

    // Double tap with an 8-cycle gap.
    s_tap = tap_cnt; s_dtap = dtap_cnt;
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 8);
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("dtap_count", dtap_cnt - s_dtap, 1);
    checkOutput("dtap_no_tap", tap_cnt - s_tap, 0);
    checkOutput("dtap_delay", dtap_at - fall_at, 1);

    // Same with a 25-cycle gap: two separate taps.
    s_tap = tap_cnt; s_dtap = dtap_cnt;
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 25);
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("gap25_taps", tap_cnt - s_tap, 2);
    checkOutput("gap25_no_dtap", dtap_cnt - s_dtap, 0);

    // Long press held 80 cycles.
    s_tap = tap_cnt; s_long = long_cnt;
    applyStimulus(1, 1, 0, 80);
    #1;
    checkOutput("long_state_held", state, 4);
    checkOutput("long_delay", long_at - rise_at, 1 + LONG);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("long_state_idle", state, 0);
    checkOutput("long_count", long_cnt - s_long, 1);
    checkOutput("long_no_tap", tap_cnt - s_tap, 0);

    // Tap followed by a held second press.
    s_tap = tap_cnt; s_dtap = dtap_cnt; s_long = long_cnt;
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 8);
    applyStimulus(1, 1, 0, 60);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("p2held_long", long_cnt - s_long, 1);
    checkOutput("p2held_no_dtap", dtap_cnt - s_dtap, 0);
    checkOutput("p2held_no_tap", tap_cnt - s_tap, 0);

    // Enable dropped during the gap.
    s_tap = tap_cnt;
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 10);
    #1;
    checkOutput("en_drop_in_gap", state, 2);
    applyStimulus(0, 0, 0, 1);
    #1;
    checkOutput("en_drop_state", state, 0);
    applyStimulus(0, 0, 0, 30);
    applyStimulus(0, 1, 0, 10);
    #1;
    checkOutput("en_drop_no_tap", tap_cnt - s_tap, 0);

    // Reset asserted during PRESS1.
    s_tap = tap_cnt; s_dtap = dtap_cnt; s_long = long_cnt;
    applyStimulus(1, 1, 0, 10);
    #1;
    checkOutput("rst_mid_press1", state, 1);
    applyStimulus(0, 1, 1, 2);
    #1;
    checkOutput("rst_mid_touched", touched, 0);
    checkOutput("rst_mid_state", state, 0);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("rst_mid_no_pulse", (tap_cnt - s_tap) + (dtap_cnt - s_dtap) + (long_cnt - s_long), 0);

    // Enable raised while already touched.
    s_tap = tap_cnt; s_dtap = dtap_cnt; s_long = long_cnt;
    applyStimulus(1, 0, 0, 20);
    applyStimulus(1, 1, 0, 20);
    #1;
    checkOutput("en_rise_held_state", state, 0);
    applyStimulus(0, 1, 0, 30);
    #1;
    checkOutput("en_rise_no_pulse", (tap_cnt - s_tap) + (dtap_cnt - s_dtap) + (long_cnt - s_long), 0);
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 40);
    #1;
    checkOutput("en_rise_fresh_tap", tap_cnt - s_tap, 1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 49));
      applyStimulus(bit'($urandom_range(0, 1)), (r % 16) != 0, r == 0,
                    (r == 0) ? 2 : int'($urandom_range(1, 70)));
    end
    applyStimulus(0, 1, 0, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
